// File: rtl/pkt_gen_multi.sv
// pkt_gen_multi
//   Burst test-packet generator for the UDP/IP transmit path. Each accepted
//   start produces cfg_num packets of cfg_len bytes, separated by cfg_gap idle
//   cycles, carrying an incrementing, fixed or PRBS payload. Byte 0 of a
//   packet sits in the MSB byte of dout.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle start pulse, sampled only while idle
//   abort             finish the current packet, then end the burst
//   cfg_len/num/gap   packet length (bytes), packets per burst, inter-packet gap
//   cfg_mode          0/3 incrementing, 1 fixed word, 2 PRBS
//   cfg_seed          fixed word (mode 1) or LFSR seed (mode 2)
//   busy              burst in progress
//   dout, dout_vld, dout_sop, dout_eop, dout_mty   beat stream (mty = pad bytes on eop)
//   rdy               downstream ready; a beat moves on dout_vld & rdy
//   pkt_cnt           packets completed in the current or last burst
module pkt_gen_multi #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16,
  parameter int NUM_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [((DATA_W/8) > 1 ? $clog2(DATA_W/8) : 1)-1:0] dout_mty,
  input  logic              rdy,
  output logic [NUM_W-1:0]  pkt_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int MTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LEN_W:0] BYTES_L = (LEN_W+1)'(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Zero every byte lane at or beyond the bytes remaining in the packet
  function automatic logic [DATA_W-1:0] pad_zero(input logic [DATA_W-1:0] w,
                                                 input logic [LEN_W:0]    rem);
    logic [DATA_W-1:0] r;
    r = w;
    for (int j = 0; j < BYTES; j++)
      if ((LEN_W+1)'(j) >= rem) r[DATA_W-1-8*j -: 8] = 8'h00;
    return r;
  endfunction

  // Incrementing pattern: lane j carries (packet byte index) mod 256
  function automatic logic [DATA_W-1:0] inc_word(input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < BYTES; j++)
      r[DATA_W-1-8*j -: 8] = b + 8'(j);
    return r;
  endfunction

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic [MTY_W-1:0]   mty_q, mty_d;
  logic [NUM_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  seed_q, seed_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [LEN_W:0]     byte_q, byte_d;      // byte index of the next beat to load
  logic               abort_q, abort_d;

  logic               idle, acc, abort_eff, ld_beat, clr_beat;
  logic [LEN_W:0]     ld_byte, rem;
  logic [DATA_W-1:0]  raw;
  logic [NUM_W-1:0]   cnt_inc;
  logic [LEN_W-1:0]   cur_len;
  logic [1:0]         cur_mode;
  logic [DATA_W-1:0]  cur_seed;
  logic [31:0]        cur_lfsr;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    dout_d    = dout_q;
    vld_d     = vld_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    mty_d     = mty_q;
    pkt_cnt_d = pkt_cnt_q;
    len_d     = len_q;
    num_d     = num_q;
    gap_d     = gap_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    lfsr_d    = lfsr_q;
    byte_d    = byte_q;
    gap_cnt_d = gap_cnt_q;
    abort_d   = abort_q;
    ld_beat   = 1'b0;
    clr_beat  = 1'b0;
    ld_byte   = '0;
    rem       = '0;
    raw       = '0;

    // The first beat is built in the start cycle, straight from the cfg inputs
    idle      = (state_q == IDLE);
    cur_len   = idle ? cfg_len  : len_q;
    cur_mode  = idle ? cfg_mode : mode_q;
    cur_seed  = idle ? cfg_seed : seed_q;
    cur_lfsr  = !idle ? lfsr_q : ((cfg_seed == '0) ? 32'd1 : 32'(cfg_seed));
    acc       = vld_q & rdy;
    abort_eff = abort_q | abort;
    cnt_inc   = pkt_cnt_q + NUM_W'(1);

    if (!idle && abort) abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && (cfg_len != '0) && (cfg_num != '0)) begin
          len_d     = cfg_len;
          num_d     = cfg_num;
          gap_d     = cfg_gap;
          mode_d    = cfg_mode;
          seed_d    = cfg_seed;
          pkt_cnt_d = '0;
          busy_d    = 1'b1;
          abort_d   = 1'b0;
          state_d   = SEND;
          ld_beat   = 1'b1;
        end
      end
      SEND: begin
        if (acc) begin
          if (eop_q) begin
            pkt_cnt_d = cnt_inc;
            if ((cnt_inc == num_q) || abort_eff) begin
              state_d  = IDLE;
              busy_d   = 1'b0;
              abort_d  = 1'b0;
              clr_beat = 1'b1;
            end else if (gap_q == '0) begin
              ld_beat = 1'b1;
            end else begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
              clr_beat  = 1'b1;
            end
          end else begin
            ld_beat = 1'b1;
            ld_byte = byte_q;
          end
        end
      end
      GAP: begin
        if (abort_eff) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          abort_d  = 1'b0;
          clr_beat = 1'b1;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
          ld_beat = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_beat) begin
      vld_d  = 1'b0;
      sop_d  = 1'b0;
      eop_d  = 1'b0;
      mty_d  = '0;
      dout_d = '0;
    end

    // Beats are only loaded when the output register is empty or just accepted,
    // so a stalled beat holds stable; the LFSR therefore steps once per beat.
    if (ld_beat) begin
      rem = {1'b0, cur_len} - ld_byte;
      case (cur_mode)
        2'd1:    raw = cur_seed;
        2'd2:    raw = cur_lfsr[DATA_W-1:0];
        default: raw = inc_word(ld_byte[7:0]);
      endcase
      dout_d = pad_zero(raw, rem);
      vld_d  = 1'b1;
      sop_d  = (ld_byte == '0);
      eop_d  = (rem <= BYTES_L);
      mty_d  = eop_d ? MTY_W'(BYTES_L - rem) : '0;
      byte_d = ld_byte + BYTES_L;
      lfsr_d = lfsr_step(cur_lfsr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      mty_q     <= '0;
      pkt_cnt_q <= '0;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      lfsr_q    <= 32'd1;
      byte_q    <= '0;
      gap_cnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      mty_q     <= mty_d;
      pkt_cnt_q <= pkt_cnt_d;
      len_q     <= len_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      lfsr_q    <= lfsr_d;
      byte_q    <= byte_d;
      gap_cnt_q <= gap_cnt_d;
      abort_q   <= abort_d;
    end
  end

  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;
  assign dout_mty = mty_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_gen_multi.sv
`timescale 1ns/1ps
module tb_pkt_gen_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rdy = 1'b1;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_num = '0;
  logic [7:0]  cfg_gap = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_seed = '0;
  logic        busy, dout_vld, dout_sop, dout_eop;
  logic [15:0] dout;
  logic [0:0]  dout_mty;
  logic [15:0] pkt_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic [0:0]  mty;
  } beat_t;

  beat_t       beats[$];
  int          gaps[$];
  logic        busy_after[$];
  logic [15:0] exp_d[$];
  logic        after_eop = 1'b0;
  logic        eop_seen = 1'b0;
  int          idle_n = 0;

  always #5 clk = ~clk;

  pkt_gen_multi #(.DATA_W(16), .LEN_W(16), .NUM_W(16), .GAP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg_len  (cfg_len),
    .cfg_num  (cfg_num),
    .cfg_gap  (cfg_gap),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout_mty (dout_mty),
    .rdy      (rdy),
    .pkt_cnt  (pkt_cnt)
  );

  // Stream monitor: records accepted beats, idle cycles between an eop and
  // the next valid beat, and busy one cycle after each eop acceptance.
  always @(negedge clk) begin
    if (eop_seen) busy_after.push_back(busy);
    if (after_eop) begin
      if (dout_vld) begin
        gaps.push_back(idle_n);
        after_eop <= 1'b0;
      end else begin
        idle_n <= idle_n + 1;
      end
    end
    if (dout_vld && rdy) begin
      beats.push_back({dout, dout_sop, dout_eop, dout_mty});
      if (dout_eop) begin
        after_eop <= 1'b1;
        idle_n    <= 0;
      end
    end
    if (!busy) after_eop <= 1'b0;
    eop_seen <= dout_vld && rdy && dout_eop;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    beats.delete();
    gaps.delete();
    busy_after.delete();
    exp_d.delete();
  endtask

  task automatic do_start(input logic [15:0] len, input logic [15:0] num,
                          input logic [7:0] gap, input logic [1:0] mode,
                          input logic [15:0] seed);
    cfg_len  = len;
    cfg_num  = num;
    cfg_gap  = gap;
    cfg_mode = mode;
    cfg_seed = seed;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, busy, 0);
    tick();
  endtask

  task automatic check_stream(input string tag, input int bpp, input int mty);
    chk({tag, "_nbeats"}, beats.size(), exp_d.size());
    for (int i = 0; i < beats.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), beats[i].d, exp_d[i]);
      chk($sformatf("%s_sop%0d", tag, i), beats[i].sop, (i % bpp) == 0);
      chk($sformatf("%s_eop%0d", tag, i), beats[i].eop, (i % bpp) == bpp - 1);
      chk($sformatf("%s_mty%0d", tag, i), beats[i].mty, ((i % bpp) == bpp - 1) ? mty : 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"},  dout_vld, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_sop"},  dout_sop, 0);
    chk({tag, "_eop"},  dout_eop, 0);
    chk({tag, "_mty"},  dout_mty, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("rst");
    chk("rst_cnt", pkt_cnt, 0);
    rst = 1'b0;
    tick();

    // 5-byte single packet, incrementing: odd length leaves one pad byte
    clear_q();
    exp_d.push_back(16'h0001); exp_d.push_back(16'h0203); exp_d.push_back(16'h0400);
    do_start(16'd5, 16'd1, 8'd0, 2'd0, 16'h0000);
    chk("t1_busy", busy, 1);
    chk("t1_first", {dout_vld, dout_sop, dout}, {2'b11, 16'h0001});
    wait_idle("t1");
    check_stream("t1", 3, 1);
    chk("t1_cnt", pkt_cnt, 1);
    chk("t1_nbusy", busy_after.size(), 1);
    if (busy_after.size() == 1) chk("t1_busyfall", busy_after[0], 0);

    // Three packets with two idle cycles between each
    clear_q();
    for (int p = 0; p < 3; p++) begin
      exp_d.push_back(16'h0001); exp_d.push_back(16'h0203);
    end
    do_start(16'd4, 16'd3, 8'd2, 2'd0, 16'h0000);
    wait_idle("t2");
    check_stream("t2", 2, 0);
    chk("t2_ngaps", gaps.size(), 2);
    for (int i = 0; i < gaps.size(); i++) chk($sformatf("t2_gap%0d", i), gaps[i], 2);
    chk("t2_cnt", pkt_cnt, 3);
    if (busy_after.size() == 3) chk("t2_busy_mid", busy_after[0], 1);

    // Backpressure on beat 2: it must hold stable and transfer once
    clear_q();
    exp_d.push_back(16'h0001); exp_d.push_back(16'h0203); exp_d.push_back(16'h0405);
    do_start(16'd6, 16'd1, 8'd0, 2'd0, 16'h0000);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_hold%0d", i), {dout_vld, dout_sop, dout_eop, dout}, {3'b100, 16'h0203});
    end
    rdy = 1'b1;
    wait_idle("t3");
    check_stream("t3", 3, 0);

    // Fixed word with pad byte zeroed
    clear_q();
    exp_d.push_back(16'hA5A5); exp_d.push_back(16'hA500);
    do_start(16'd3, 16'd1, 8'd0, 2'd1, 16'hA5A5);
    wait_idle("t4a");
    check_stream("t4a", 2, 1);

    // PRBS from a zero seed, sequence continuing into the second packet
    clear_q();
    exp_d.push_back(16'h0001); exp_d.push_back(16'h0003);
    exp_d.push_back(16'h0006); exp_d.push_back(16'h000D);
    do_start(16'd4, 16'd2, 8'd0, 2'd2, 16'h0000);
    wait_idle("t4b");
    check_stream("t4b", 2, 0);
    chk("t4b_cnt", pkt_cnt, 2);

    // Abort during packet 2 of 5: packet 2 completes, nothing after it
    clear_q();
    for (int p = 0; p < 2; p++) begin
      exp_d.push_back(16'h0001); exp_d.push_back(16'h0203);
    end
    do_start(16'd4, 16'd5, 8'd0, 2'd0, 16'h0000);
    tick();
    tick();
    chk("t5_p2sop", {dout_vld, dout_sop}, 2'b11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("t5");
    check_stream("t5", 2, 0);
    chk("t5_cnt", pkt_cnt, 2);

    // Abort while idle is ignored; single-beat packets carry sop and eop together
    clear_q();
    exp_d.push_back(16'h0001); exp_d.push_back(16'h0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_start(16'd2, 16'd2, 8'd0, 2'd0, 16'h0000);
    wait_idle("t7");
    check_stream("t7", 1, 0);
    chk("t7_cnt", pkt_cnt, 2);

    // Reset mid-packet: outputs drop at once, no recovery beat
    clear_q();
    do_start(16'd8, 16'd3, 8'd0, 2'd0, 16'h0000);
    tick();
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    chk("t6_rst_cnt", pkt_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t6_after_vld", dout_vld, 0);
    chk("t6_nbeats", beats.size(), 1);

    // Illegal configurations are ignored
    clear_q();
    do_start(16'd0, 16'd1, 8'd0, 2'd0, 16'h0000);
    chk("t8_len0_busy", busy, 0);
    chk("t8_len0_vld", dout_vld, 0);
    do_start(16'd4, 16'd0, 8'd0, 2'd0, 16'h0000);
    chk("t8_num0_busy", busy, 0);
    tick();
    tick();
    chk("t8_nbeats", beats.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
